// File: rtl/hsem_lock_array.sv
// Hardware-semaphore core: NUM_SEM lock entries, each holding an owner master ID and
// process ID, reachable through a simple word-addressed register bus.
// Supports two-step (write) locking, one-step read-to-lock, a keyed per-master clear-all
// and a maskable interrupt raised whenever an entry goes from LOCKED to FREE.
// Optional feature: define HSEM_TIMEOUT_EN to give every entry a hold counter that
// force-releases the lock after TIMEOUT_CYC locked cycles.
module hsem_lock_array #(
    parameter int unsigned NUM_SEM     = 16,
    parameter int unsigned MID_W       = 4,
    parameter int unsigned PID_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        ihwdata,
    input  logic [MID_W-1:0]   mid,
    output logic [31:0]        ihrdata,
    output logic [NUM_SEM-1:0] sem_locked,
    output logic               lock_err,
    output logic               intr
);

    localparam int unsigned IDX_W    = (NUM_SEM > 1) ? $clog2(NUM_SEM) : 1;
    localparam logic [7:0]  ADDR_IER = 8'h40;
    localparam logic [7:0]  ADDR_ISR = 8'h41;
    localparam logic [7:0]  ADDR_CLR = 8'h42;
    localparam logic [7:0]  ADDR_KEY = 8'h43;

    // Entry state: lock flag plus owner identity
    logic [NUM_SEM-1:0]             lock_q, lock_d;
    logic [NUM_SEM-1:0][MID_W-1:0]  mid_q,  mid_d;
    logic [NUM_SEM-1:0][PID_W-1:0]  pid_q,  pid_d;

    // Control/status registers and registered outputs
    logic [NUM_SEM-1:0] ier_q, ier_d;
    logic [NUM_SEM-1:0] isr_q, isr_d;
    logic [15:0]        key_q, key_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [NUM_SEM-1:0] sem_q;
    logic               intr_q;

    // Release sources and W1C mask
    logic [NUM_SEM-1:0] bus_rel;
    logic [NUM_SEM-1:0] rel;
    logic [NUM_SEM-1:0] w1c;
    logic [NUM_SEM-1:0] tmo;

    // Address decode
    logic [IDX_W-1:0] idx;
    logic             idx_ok;
    logic             is_r;
    logic             is_rlr;
    logic [MID_W-1:0] wmid;
    logic [PID_W-1:0] wpid;

    assign idx    = reg_addr[IDX_W-1:0];
    assign idx_ok = ({3'b000, reg_addr[4:0]} < 8'(NUM_SEM));
    assign is_r   = (reg_addr[7:5] == 3'b000) && idx_ok;
    assign is_rlr = (reg_addr[7:5] == 3'b001) && idx_ok;
    assign wmid   = ihwdata[8 +: MID_W];
    assign wpid   = ihwdata[0 +: PID_W];

    // Pack one entry into its bus-visible word {LOCK, 0, MID, PID}
    function automatic logic [31:0] entry_word(input logic            locked,
                                               input logic [MID_W-1:0] m,
                                               input logic [PID_W-1:0] p);
        logic [31:0] w;
        w             = '0;
        w[31]         = locked;
        w[8 +: MID_W] = m;
        w[0 +: PID_W] = p;
        return w;
    endfunction

    // Bus access decode, entry next-state, status update and read-data mux
    always_comb begin
        lock_d  = lock_q;
        mid_d   = mid_q;
        pid_d   = pid_q;
        ier_d   = ier_q;
        key_d   = key_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        bus_rel = '0;
        rel     = '0;
        w1c     = '0;

        if (wr_en) begin
            if (is_r) begin
                if (ihwdata[31]) begin
                    if (!lock_q[idx]) begin
                        if (wmid == mid) begin
                            lock_d[idx] = 1'b1;
                            mid_d[idx]  = wmid;
                            pid_d[idx]  = wpid;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (!((mid_q[idx] == wmid) && (pid_q[idx] == wpid) &&
                                   (wmid == mid))) begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (lock_q[idx] && (mid_q[idx] == wmid) && (pid_q[idx] == wpid)) begin
                        bus_rel[idx] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end else if (reg_addr == ADDR_IER) begin
                ier_d = ihwdata[NUM_SEM-1:0];
            end else if (reg_addr == ADDR_ISR) begin
                w1c = ihwdata[NUM_SEM-1:0];
            end else if (reg_addr == ADDR_CLR) begin
                if (ihwdata[31:16] == key_q) begin
                    for (int i = 0; i < NUM_SEM; i++) begin
                        if (lock_q[i] && (mid_q[i] == wmid)) begin
                            bus_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else if (reg_addr == ADDR_KEY) begin
                key_d = ihwdata[15:0];
            end
        end else if (rd_en) begin
            rdata_d = '0;
            if (is_r) begin
                rdata_d = entry_word(lock_q[idx], mid_q[idx], pid_q[idx]);
            end else if (is_rlr) begin
                if (!lock_q[idx]) begin
                    lock_d[idx] = 1'b1;
                    mid_d[idx]  = mid;
                    pid_d[idx]  = '0;
                    rdata_d     = entry_word(1'b1, mid, '0);
                end else begin
                    rdata_d = entry_word(1'b1, mid_q[idx], pid_q[idx]);
                end
            end else if (reg_addr == ADDR_IER) begin
                rdata_d[NUM_SEM-1:0] = ier_q;
            end else if (reg_addr == ADDR_ISR) begin
                rdata_d[NUM_SEM-1:0] = isr_q;
            end else if (reg_addr == ADDR_KEY) begin
                rdata_d[15:0] = key_q;
            end
        end

        // A forced release only counts as an error when the bus did not free it too
        for (int i = 0; i < NUM_SEM; i++) begin
            if (tmo[i] && !bus_rel[i]) begin
                err_d = 1'b1;
            end
        end

        // Merge all release sources so a doubly-released entry sets ISR once
        rel = bus_rel | tmo;
        for (int i = 0; i < NUM_SEM; i++) begin
            if (rel[i]) begin
                lock_d[i] = 1'b0;
                mid_d[i]  = '0;
                pid_d[i]  = '0;
            end
        end

        isr_d = (isr_q & ~w1c) | rel;
    end

`ifdef HSEM_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [NUM_SEM-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Flag entries whose hold time has run out
    always_comb begin
        tmo = '0;
        for (int i = 0; i < NUM_SEM; i++) begin
            tmo[i] = lock_q[i] && (cnt_q[i] == CNT_LAST);
        end
    end

    // Hold counters restart on every new lock and saturate at the last count
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_SEM; i++) begin
            if (!lock_q[i] || !lock_d[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_LAST) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Hold counter registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = '0;
`endif

    // State, status and output registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lock_q  <= '0;
            mid_q   <= '0;
            pid_q   <= '0;
            ier_q   <= '0;
            isr_q   <= '0;
            key_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            sem_q   <= '0;
            intr_q  <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            mid_q   <= mid_d;
            pid_q   <= pid_d;
            ier_q   <= ier_d;
            isr_q   <= isr_d;
            key_q   <= key_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            sem_q   <= lock_q;
            intr_q  <= |(isr_q & ier_q);
        end
    end

    assign ihrdata    = rdata_q;
    assign sem_locked = sem_q;
    assign lock_err   = err_q;
    assign intr       = intr_q;

endmodule

// File: tb/tb_hsem_lock_array.sv
// Self-checking bench for hsem_lock_array: a table of directed register accesses with
// hand-computed read data and lock_err values, plus short sequences for interrupt timing,
// read-data hold, reset during an access and (with HSEM_TIMEOUT_EN) hold timeouts.
module tb_hsem_lock_array;

    logic        hclk;
    logic        hresetn;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  reg_addr;
    logic [31:0] ihwdata;
    logic [3:0]  mid;
    logic [31:0] ihrdata;
    logic [15:0] sem_locked;
    logic        lock_err;
    logic        intr;

    int checks;
    int errors;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  mid;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    hsem_lock_array #(
        .NUM_SEM     (16),
        .MID_W       (4),
        .PID_W       (8),
        .TIMEOUT_CYC (8)
    ) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .reg_addr   (reg_addr),
        .ihwdata    (ihwdata),
        .mid        (mid),
        .ihrdata    (ihrdata),
        .sem_locked (sem_locked),
        .lock_err   (lock_err),
        .intr       (intr)
    );

    // Free-running 100 MHz clock
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one access on the falling edge and sample just after the next rising edge
    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] a,
                                 input logic [31:0] d, input logic [3:0] m);
        @(negedge hclk);
        wr_en    = w;
        rd_en    = r;
        reg_addr = a;
        ihwdata  = d;
        mid      = m;
        @(posedge hclk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addWr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic e);
        vec_t v;
        v = '{1'b1, 1'b0, a, d, m, 1'b0, 32'h0, e};
        vq.push_back(v);
    endtask

    task automatic addRd(input logic [7:0] a, input logic [3:0] m, input logic [31:0] x);
        vec_t v;
        v = '{1'b0, 1'b1, a, 32'h0, m, 1'b1, x, 1'b0};
        vq.push_back(v);
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        hresetn  = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        reg_addr = 8'h00;
        ihwdata  = 32'h0;
        mid      = 4'h0;

        repeat (3) @(posedge hclk);
        #1;
        checkOutput("rst_ihrdata", ihrdata, 32'h0);
        checkOutput("rst_sem_locked", {16'h0, sem_locked}, 32'h0);
        checkOutput("rst_intr", {31'h0, intr}, 32'h0);
        checkOutput("rst_lock_err", {31'h0, lock_err}, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;

        // Every entry reads back FREE after reset
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 32'h0, 4'h0);
            checkOutput($sformatf("rst_R%0d", i), ihrdata, 32'h0);
        end

`ifndef HSEM_TIMEOUT_EN
        addWr(8'h02, 32'h8000_0305, 4'd3, 1'b0);
        addRd(8'h02, 4'd3, 32'h8000_0305);
        addWr(8'h02, 32'h8000_0105, 4'd1, 1'b1);
        addRd(8'h02, 4'd1, 32'h8000_0305);
        addWr(8'h02, 32'h8000_0305, 4'd3, 1'b0);
        addWr(8'h02, 32'h8000_0306, 4'd3, 1'b1);
        addRd(8'h27, 4'd5, 32'h8000_0500);
        addRd(8'h27, 4'd6, 32'h8000_0500);
        addRd(8'h07, 4'd6, 32'h8000_0500);
        addWr(8'h40, 32'h0000_0004, 4'd0, 1'b0);
        addRd(8'h40, 4'd0, 32'h0000_0004);
        addWr(8'h02, 32'h0000_0305, 4'd3, 1'b0);
        addRd(8'h41, 4'd0, 32'h0000_0004);
        addRd(8'h02, 4'd0, 32'h0000_0000);
        addWr(8'h02, 32'h0000_0305, 4'd3, 1'b1);
        addWr(8'h41, 32'h0000_0004, 4'd0, 1'b0);
        addRd(8'h41, 4'd0, 32'h0000_0000);
        addWr(8'h03, 32'h8000_0409, 4'd3, 1'b1);
        addRd(8'h03, 4'd3, 32'h0000_0000);
        addWr(8'h23, 32'h8000_0305, 4'd3, 1'b0);
        addRd(8'h03, 4'd3, 32'h0000_0000);
        addWr(8'h43, 32'h0000_A5A5, 4'd0, 1'b0);
        addRd(8'h43, 4'd0, 32'h0000_A5A5);
        addWr(8'h00, 32'h8000_0211, 4'd2, 1'b0);
        addWr(8'h01, 32'h8000_0222, 4'd2, 1'b0);
        addWr(8'h42, 32'h1234_0200, 4'd2, 1'b1);
        addRd(8'h00, 4'd2, 32'h8000_0211);
        addWr(8'h42, 32'hA5A5_0200, 4'd2, 1'b0);
        addRd(8'h41, 4'd0, 32'h0000_0003);
        addRd(8'h00, 4'd0, 32'h0000_0000);
        addRd(8'h01, 4'd0, 32'h0000_0000);
        addRd(8'h07, 4'd0, 32'h8000_0500);
        addRd(8'h50, 4'd0, 32'h0000_0000);
        addWr(8'h50, 32'hFFFF_FFFF, 4'd0, 1'b0);
        addWr(8'h14, 32'h8000_0300, 4'd3, 1'b0);
        addRd(8'h14, 4'd3, 32'h0000_0000);
        addRd(8'h34, 4'd3, 32'h0000_0000);
        addRd(8'h08, 4'd3, 32'h0000_0000);

        for (int k = 0; k < vq.size(); k++) begin
            applyStimulus(vq[k].wr, vq[k].rd, vq[k].addr, vq[k].wdata, vq[k].mid);
            checkOutput($sformatf("v%0d_lock_err", k), {31'h0, lock_err}, {31'h0, vq[k].exp_err});
            if (vq[k].chk_rd) begin
                checkOutput($sformatf("v%0d_ihrdata", k), ihrdata, vq[k].exp_rd);
            end
        end

        // sem_locked lags the entry state; intr follows ISR one cycle later
        idleCycles(1);
        checkOutput("seq_sem_r7", {16'h0, sem_locked}, 32'h0000_0080);
        applyStimulus(1'b1, 1'b0, 8'h02, 32'h8000_0305, 4'd3);
        idleCycles(1);
        checkOutput("seq_sem_r2r7", {16'h0, sem_locked}, 32'h0000_0084);
        applyStimulus(1'b1, 1'b0, 8'h02, 32'h0000_0305, 4'd3);
        checkOutput("seq_intr_lag", {31'h0, intr}, 32'h0);
        idleCycles(1);
        checkOutput("seq_intr_set", {31'h0, intr}, 32'h1);
        checkOutput("seq_sem_after_rel", {16'h0, sem_locked}, 32'h0000_0080);
        applyStimulus(1'b1, 1'b0, 8'h41, 32'h0000_0004, 4'd0);
        idleCycles(1);
        checkOutput("seq_intr_clr", {31'h0, intr}, 32'h0);

        // ihrdata holds while idle and when a write collides with a read
        applyStimulus(1'b0, 1'b1, 8'h07, 32'h0, 4'd0);
        idleCycles(3);
        checkOutput("seq_hold_idle", ihrdata, 32'h8000_0500);
        applyStimulus(1'b1, 1'b1, 8'h43, 32'h0000_1111, 4'd0);
        checkOutput("seq_wrrd_hold", ihrdata, 32'h8000_0500);
        applyStimulus(1'b0, 1'b1, 8'h43, 32'h0, 4'd0);
        checkOutput("seq_wrrd_key", ihrdata, 32'h0000_1111);
        applyStimulus(1'b1, 1'b1, 8'h29, 32'h0, 4'd4);
        checkOutput("seq_wrrd_rlr_hold", ihrdata, 32'h0000_1111);
        applyStimulus(1'b0, 1'b1, 8'h09, 32'h0, 4'd4);
        checkOutput("seq_wrrd_rlr_free", ihrdata, 32'h0);
        applyStimulus(1'b0, 1'b1, 8'h43, 32'h0, 4'd0);

        // Reset asserted while a lock write is on the bus
        @(negedge hclk);
        wr_en    = 1'b1;
        reg_addr = 8'h05;
        ihwdata  = 32'h8000_0401;
        mid      = 4'd4;
        #2;
        hresetn = 1'b0;
        @(posedge hclk);
        #1;
        wr_en = 1'b0;
        checkOutput("mrst_ihrdata", ihrdata, 32'h0);
        checkOutput("mrst_sem_locked", {16'h0, sem_locked}, 32'h0);
        checkOutput("mrst_lock_err", {31'h0, lock_err}, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h07, 32'h0, 4'd0);
        checkOutput("mrst_R7", ihrdata, 32'h0);
        applyStimulus(1'b0, 1'b1, 8'h05, 32'h0, 4'd0);
        checkOutput("mrst_R5", ihrdata, 32'h0);
        applyStimulus(1'b0, 1'b1, 8'h43, 32'h0, 4'd0);
        checkOutput("mrst_KEY", ihrdata, 32'h0);
`else
        // Lock R[0]; release must land exactly 8 cycles later and beat a same-cycle W1C
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h8000_0211, 4'd2);
        checkOutput("tmo0_lock_err", {31'h0, lock_err}, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            idleCycles(1);
            checkOutput($sformatf("tmo0_early_c%0d", c), {31'h0, lock_err}, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 8'h41, 32'h0000_0001, 4'd0);
        checkOutput("tmo0_fire_err", {31'h0, lock_err}, 32'h1);
        applyStimulus(1'b0, 1'b1, 8'h41, 32'h0, 4'd0);
        checkOutput("tmo0_isr", ihrdata, 32'h0000_0001);
        applyStimulus(1'b0, 1'b1, 8'h00, 32'h0, 4'd0);
        checkOutput("tmo0_R0", ihrdata, 32'h0);

        // Owner unlock on the timeout cycle: single release, no error
        applyStimulus(1'b1, 1'b0, 8'h41, 32'h0000_FFFF, 4'd0);
        applyStimulus(1'b1, 1'b0, 8'h01, 32'h8000_0233, 4'd2);
        idleCycles(7);
        applyStimulus(1'b1, 1'b0, 8'h01, 32'h0000_0233, 4'd2);
        checkOutput("tmo1_unlock_err", {31'h0, lock_err}, 32'h0);
        applyStimulus(1'b0, 1'b1, 8'h41, 32'h0, 4'd0);
        checkOutput("tmo1_isr", ihrdata, 32'h0000_0002);
        applyStimulus(1'b0, 1'b1, 8'h01, 32'h0, 4'd0);
        checkOutput("tmo1_R1", ihrdata, 32'h0);

        // Read-to-lock also starts the hold counter
        applyStimulus(1'b0, 1'b1, 8'h25, 32'h0, 4'd4);
        checkOutput("tmo2_rlr", ihrdata, 32'h8000_0400);
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            idleCycles(1);
            if (lock_err && (n == 0)) begin
                n = c;
            end
        end
        checkOutput("tmo2_cycles", 32'(n), 32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
